sseg_scan_decoder: RTL and testbench

//  Receive side of the 7-segment display interface. Samples a multiplexed display bus
//  (one-hot anode select plus 8-bit segment word: dp in bit 7, segments a..g in bits 6..0).

---
 rtl/sseg_scan_decoder.sv | 158 +++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_decoder.sv
// Receive side of a multiplexed 7-segment display bus: debounces each digit slot
// and decodes the segment pattern back into per-slot hex nibble, dp, valid and err registers.
module sseg_scan_decoder #(
  parameter int N_DIGITS      = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_DIGITS-1:0]     an,
  input  logic [7:0]              sseg,
  output logic [4*N_DIGITS-1:0]   digits,
  output logic [N_DIGITS-1:0]     dp_out,
  output logic [N_DIGITS-1:0]     valid,
  output logic [N_DIGITS-1:0]     err,
  output logic                    upd,
  output logic [2:0]              upd_idx
);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  state_t              state, state_next;
  logic [N_DIGITS-1:0] an_q, ref_an, sel;
  logic [7:0]          sseg_q, ref_sseg;
  logic [7:0]          cnt, cnt_next;
  logic                legal, same, load_ref, commit;
  logic [2:0]          sel_idx;
  logic [3:0]          code;
  logic                is_hex, is_blank;

  assign sel   = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
  assign legal = $onehot(sel);
  assign same  = (an_q == ref_an) && (sseg_q == ref_sseg);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (sel[i]) sel_idx = 3'(i);
  end

  // Segment word (a..g in bits 6..0) back to the hex nibble it displays.
  always_comb begin
    code     = 4'h0;
    is_hex   = 1'b1;
    is_blank = 1'b0;
    case (sseg_q[6:0])
      7'h7E: code = 4'h0;
      7'h30: code = 4'h1;
      7'h6D: code = 4'h2;
      7'h79: code = 4'h3;
      7'h33: code = 4'h4;
      7'h5B: code = 4'h5;
      7'h5F: code = 4'h6;
      7'h70: code = 4'h7;
      7'h7F: code = 4'h8;
      7'h7B: code = 4'h9;
      7'h77: code = 4'hA;
      7'h1F: code = 4'hB;
      7'h4E: code = 4'hC;
      7'h3D: code = 4'hD;
      7'h4F: code = 4'hE;
      7'h47: code = 4'hF;
      7'h00: begin is_hex = 1'b0; is_blank = 1'b1; end
      default: is_hex = 1'b0;
    endcase
  end

  // Commit fires on the same edge that sees the STABLE_CYCLES-th matching sample.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_ref   = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          cnt_next   = 8'd1;
          load_ref   = 1'b1;
          state_next = TRACK;
        end
      end
      TRACK: begin
        if (!legal) begin
          cnt_next   = 8'd0;
          state_next = IDLE;
        end else if (same) begin
          cnt_next = (cnt >= STABLE) ? STABLE : cnt + 8'd1;
          if (cnt_next == STABLE) begin
            commit     = 1'b1;
            state_next = HELD;
          end
        end else begin
          cnt_next = 8'd1;
          load_ref = 1'b1;
        end
      end
      HELD: begin
        if (!legal) begin
          cnt_next   = 8'd0;
          state_next = IDLE;
        end else if (!same) begin
          cnt_next   = 8'd1;
          load_ref   = 1'b1;
          state_next = TRACK;
        end
      end
      default: begin
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q     <= '0;
      sseg_q   <= '0;
      ref_an   <= '0;
      ref_sseg <= '0;
      cnt      <= '0;
      state    <= IDLE;
      digits   <= '0;
      dp_out   <= '0;
      valid    <= '0;
      err      <= '0;
      upd      <= 1'b0;
      upd_idx  <= '0;
    end else begin
      an_q   <= an;
      sseg_q <= sseg;
      state  <= state_next;
      cnt    <= cnt_next;
      upd    <= commit;
      if (load_ref) begin
        ref_an   <= an_q;
        ref_sseg <= sseg_q;
      end
      if (commit) upd_idx <= sel_idx;
      // A legal sample selects exactly one slot, so at most one iteration fires.
      for (int i = 0; i < N_DIGITS; i++) begin
        if (commit && sel[i]) begin
          dp_out[i] <= sseg_q[7];
          if (is_hex) begin
            digits[4*i +: 4] <= code;
            valid[i]         <= 1'b1;
            err[i]           <= 1'b0;
          end else begin
            valid[i] <= 1'b0;
            err[i]   <= !is_blank;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder (4 digits, 4-sample debounce, active-low anodes).
module tb_sseg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic [15:0] digits;
  logic [3:0]  dp_out, valid, err;
  logic        upd;
  logic [2:0]  upd_idx;

  int vectors    = 0;
  int miscompares = 0;

  sseg_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(4), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .an(an), .sseg(sseg),
    .digits(digits), .dp_out(dp_out), .valid(valid), .err(err),
    .upd(upd), .upd_idx(upd_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; an = 4'b1111; sseg = 8'h00;
    repeat (3) tick();
    vectors++; if (digits !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_digits: got %h expected 0000", digits); end
    vectors++; if (dp_out !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_dp: got %b expected 0000", dp_out); end
    vectors++; if (valid !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_valid: got %b expected 0000", valid); end
    vectors++; if (err !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_err: got %b expected 0000", err); end
    vectors++; if (upd !== 1'b0 || upd_idx !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_upd: got %b/%0d expected 0/0", upd, upd_idx); end
    rst = 1'b0;
  endtask

  task automatic test_single_digit();
    int n = 0, at = 0;
    logic [2:0] idx = '0;
    an = 4'b1110; sseg = 8'h79;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (upd === 1'b1) begin n++; if (n == 1) begin at = c; idx = upd_idx; end end
    end
    vectors++; if (n != 1) begin miscompares++; $display("[TB] FAIL t1_upd_count: got %0d expected 1", n); end
    vectors++; if (at != 5) begin miscompares++; $display("[TB] FAIL t1_latency: got edge %0d expected edge 5", at); end
    vectors++; if (idx !== 3'd0) begin miscompares++; $display("[TB] FAIL t1_upd_idx: got %0d expected 0", idx); end
    vectors++; if (digits !== 16'h0003) begin miscompares++; $display("[TB] FAIL t1_digits: got %h expected 0003", digits); end
    vectors++; if (valid !== 4'b0001) begin miscompares++; $display("[TB] FAIL t1_valid: got %b expected 0001", valid); end
    vectors++; if (err !== 4'b0000 || dp_out !== 4'b0000) begin miscompares++; $display("[TB] FAIL t1_err_dp: got %b/%b expected 0000/0000", err, dp_out); end
  endtask

  task automatic test_debounce();
    int n = 0;
    logic [2:0] idx = '0;
    logic saw_one = 1'b0;
    an = 4'b1101;
    for (int c = 1; c <= 9; c++) begin
      sseg = (c <= 3) ? 8'h30 : 8'h6D;
      tick();
      if (upd === 1'b1) begin n++; idx = upd_idx; end
      if (digits[7:4] === 4'h1) saw_one = 1'b1;
    end
    vectors++; if (n != 1) begin miscompares++; $display("[TB] FAIL t2_upd_count: got %0d expected 1", n); end
    vectors++; if (idx !== 3'd1) begin miscompares++; $display("[TB] FAIL t2_upd_idx: got %0d expected 1", idx); end
    vectors++; if (saw_one !== 1'b0) begin miscompares++; $display("[TB] FAIL t2_no_commit_of_1: got %b expected 0", saw_one); end
    vectors++; if (digits !== 16'h0023) begin miscompares++; $display("[TB] FAIL t2_digits: got %h expected 0023", digits); end
    vectors++; if (valid !== 4'b0011) begin miscompares++; $display("[TB] FAIL t2_valid: got %b expected 0011", valid); end
  endtask

  task automatic test_illegal_pattern();
    int n = 0;
    logic [2:0] idx = '0;
    an = 4'b1011; sseg = 8'h01;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (upd === 1'b1) begin n++; idx = upd_idx; end
    end
    vectors++; if (n != 1 || idx !== 3'd2) begin miscompares++; $display("[TB] FAIL t3_upd: got %0d pulses idx %0d expected 1 pulse idx 2", n, idx); end
    vectors++; if (err !== 4'b0100) begin miscompares++; $display("[TB] FAIL t3_err: got %b expected 0100", err); end
    vectors++; if (valid !== 4'b0011) begin miscompares++; $display("[TB] FAIL t3_valid: got %b expected 0011", valid); end
    vectors++; if (digits !== 16'h0023) begin miscompares++; $display("[TB] FAIL t3_digits: got %h expected 0023", digits); end
  endtask

  task automatic test_blank();
    int n = 0;
    logic [2:0] idx = '0;
    an = 4'b1101; sseg = 8'h80;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (upd === 1'b1) begin n++; idx = upd_idx; end
    end
    vectors++; if (n != 1 || idx !== 3'd1) begin miscompares++; $display("[TB] FAIL blank_upd: got %0d pulses idx %0d expected 1 pulse idx 1", n, idx); end
    vectors++; if (valid !== 4'b0001) begin miscompares++; $display("[TB] FAIL blank_valid: got %b expected 0001", valid); end
    vectors++; if (err !== 4'b0100) begin miscompares++; $display("[TB] FAIL blank_err: got %b expected 0100", err); end
    vectors++; if (dp_out !== 4'b0010) begin miscompares++; $display("[TB] FAIL blank_dp: got %b expected 0010", dp_out); end
    vectors++; if (digits !== 16'h0023) begin miscompares++; $display("[TB] FAIL blank_digits: got %h expected 0023", digits); end
  endtask

  task automatic test_no_select();
    int n = 0;
    for (int c = 1; c <= 20; c++) begin
      an   = (c <= 10) ? 4'b1100 : 4'b1111;
      sseg = (c <= 10) ? 8'h79 : 8'h30;
      tick();
      if (upd === 1'b1) n++;
    end
    vectors++; if (n != 0) begin miscompares++; $display("[TB] FAIL t4_upd_count: got %0d expected 0", n); end
    vectors++; if (digits !== 16'h0023 || valid !== 4'b0001) begin miscompares++; $display("[TB] FAIL t4_digits_valid: got %h/%b expected 0023/0001", digits, valid); end
    vectors++; if (err !== 4'b0100 || dp_out !== 4'b0010) begin miscompares++; $display("[TB] FAIL t4_err_dp: got %b/%b expected 0100/0010", err, dp_out); end
  endtask

  task automatic test_scan();
    logic [3:0] an_tab [4]   = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [7:0] seg_tab [4]  = '{8'hF7, 8'h5B, 8'h4E, 8'h7F};
    logic [2:0] idx_tab [4]  = '{3'd3, 3'd2, 3'd1, 3'd0};
    int n = 0, order_bad = 0;
    for (int p = 0; p < 2; p++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 6; c++) begin
          an = an_tab[d]; sseg = seg_tab[d];
          tick();
          if (upd === 1'b1) begin
            if (upd_idx !== idx_tab[n % 4]) order_bad++;
            n++;
          end
        end
    repeat (2) begin
      tick();
      if (upd === 1'b1) n++;
    end
    vectors++; if (n != 8) begin miscompares++; $display("[TB] FAIL t5_upd_count: got %0d expected 8", n); end
    vectors++; if (order_bad != 0) begin miscompares++; $display("[TB] FAIL t5_upd_order: got %0d wrong indices expected 0", order_bad); end
    vectors++; if (digits !== 16'hA5C8) begin miscompares++; $display("[TB] FAIL t5_digits: got %h expected a5c8", digits); end
    vectors++; if (dp_out !== 4'b1000) begin miscompares++; $display("[TB] FAIL t5_dp: got %b expected 1000", dp_out); end
    vectors++; if (valid !== 4'b1111 || err !== 4'b0000) begin miscompares++; $display("[TB] FAIL t5_valid_err: got %b/%b expected 1111/0000", valid, err); end
  endtask

  task automatic test_reset_mid_run();
    int n = 0, at = 0;
    an = 4'b1101; sseg = 8'h30;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (upd === 1'b1) n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (n != 0) begin miscompares++; $display("[TB] FAIL t6_pre_upd: got %0d expected 0", n); end
    vectors++; if (digits !== 16'h0000 || valid !== 4'b0000) begin miscompares++; $display("[TB] FAIL t6_cleared: got %h/%b expected 0000/0000", digits, valid); end
    vectors++; if (dp_out !== 4'b0000 || err !== 4'b0000 || upd !== 1'b0) begin miscompares++; $display("[TB] FAIL t6_cleared_misc: got %b/%b/%b expected 0000/0000/0", dp_out, err, upd); end
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (upd === 1'b1) begin n++; if (n == 1) at = c; end
    end
    vectors++; if (n != 1 || at != 5) begin miscompares++; $display("[TB] FAIL t6_recommit: got %0d pulses at edge %0d expected 1 at edge 5", n, at); end
    vectors++; if (digits !== 16'h0010 || valid !== 4'b0010) begin miscompares++; $display("[TB] FAIL t6_result: got %h/%b expected 0010/0010", digits, valid); end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_debounce();
    test_illegal_pattern();
    test_blank();
    test_no_select();
    test_scan();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
